miss_refill_ctrl: RTL
=====================

MISS_REFILL_CTRL -- requirements
Module: miss_refill_ctrl

Interface
REQ-001 Parameters: none; geometry fixed at 4 ways, 64 sets, 64-byte lines (16 x 32-bit words), tag = addr[31:12], index = addr[11:6].
REQ-002 clk  in  1  sole clock, all state on rising edge.
REQ-003 rstn  in  1  reset, asynchronous, active-low.
REQ-004 miss  in  1  level; request refill for addr_rbuf when idle.
REQ-005 addr_rbuf  in  32  missing address (same buffer feeding LRU selector).
REQ-006 way_sel  in  4  one-hot victim way from LRU selector.
REQ-007 dirty  in  4  dirty bit per way of set addr_rbuf[11:6].
REQ-008 victim_tag  in  20  tag of way_sel way.
REQ-009 victim_data  in  512  line data of way_sel way, word k at [32k+31:32k].
REQ-010 rd_req / rd_addr  out  1 / 32  line read request, addr line-aligned.
REQ-011 rd_rdy  in  1  memory accepts rd_req this cycle.
REQ-012 ret_valid / ret_last / ret_data  in  1 / 1 / 32  read return beat, last beat flag, beat data.
REQ-013 wr_req / wr_addr  out  1 / 32  writeback request, addr line-aligned.
REQ-014 wr_valid / wr_data / wr_last  out  1 / 32 / 1  writeback data beat.
REQ-015 wr_rdy  in  1  memory accepts current request or data beat.
REQ-016 fill_we / fill_index / fill_tag / fill_data  out  4 / 6 / 20 / 512  one-cycle line write into tag+data RAM.
REQ-017 lru_en / lru_visit  out  1 / 4  LRU update strobe and one-hot visited way.
REQ-018 busy / done  out  1 / 1  refill in progress; one-cycle completion pulse.

Function
REQ-019 States: IDLE, WB_REQ, WB_DATA, RD_REQ, RD_DATA, FILL.
REQ-020 IDLE, miss=1: latch addr_rbuf, way_sel, victim_tag, victim_data, dirty-of-way_sel; next WB_REQ if that dirty bit=1, else RD_REQ.
REQ-021 miss while not IDLE ignored; inputs other than handshakes ignored after latch.
REQ-022 WB_REQ: wr_req=1, wr_addr={victim_tag, index, 6'b0}; on wr_rdy -> WB_DATA, beat counter=0.
REQ-023 WB_DATA: wr_valid=1, wr_data=latched word[counter], wr_last=(counter==15); counter increments only when wr_rdy=1; wr_rdy at counter 15 -> RD_REQ.
REQ-024 RD_REQ: rd_req=1, rd_addr={addr[31:6], 6'b0}; on rd_rdy -> RD_DATA, beat counter=0.
REQ-025 RD_DATA: each ret_valid writes ret_data into refill buffer word[counter], counter+1 (4-bit, wraps 15->0); ret_valid with ret_last -> FILL; beats with ret_valid=0 ignored.
REQ-026 ret_last arriving before 16 beats: still -> FILL, unwritten words keep prior buffer contents; beats beyond 16 overwrite from word 0.
REQ-027 FILL (exactly one cycle): fill_we=latched way, fill_index=addr[11:6], fill_tag=addr[31:12], fill_data=buffer; lru_en=1, lru_visit=latched way; done=1; -> IDLE.
REQ-028 fill_we, lru_en, done zero outside FILL; rd_req only in RD_REQ; wr_req only in WB_REQ; wr_valid only in WB_DATA.
REQ-029 busy=1 in every state except IDLE.
REQ-030 Latency clean miss, zero-wait memory: miss at cycle 0 -> rd_req cycle 1 -> beats cycles 2..17 -> FILL cycle 18 -> IDLE cycle 19.
REQ-031 miss held high through done starts a new refill the cycle after returning to IDLE.
REQ-032 Non-one-hot way_sel latched unchanged; fill_we and lru_visit reproduce it.

Reset
REQ-033 rstn low, any state, any cycle: immediately IDLE, all outputs 0, counter 0, latches and refill buffer 0.
REQ-034 Reset mid-transfer abandons outstanding burst; no fill_we or lru_en pulse produced.
REQ-035 After rstn rises, first miss accepted on the first rising edge with miss=1.

Verification
REQ-036 Clean miss addr 0x1234_5678, way_sel=0010, dirty=0000, zero-wait memory, beats 0..15 -> rd_addr 0x1234_5640, FILL cycle 18, fill_we=0010, fill_index=0x19, fill_tag=0x12345, lru_visit=0010.
REQ-037 Dirty victim way 0100, victim_tag 0xABCDE, index 0x19 -> wr_addr 0xABCDE640, 16 data beats wr_last on 16th, then rd_req.
REQ-038 wr_rdy low alternate cycles during WB_DATA -> wr_data holds until accepted, each word sent once in order.
REQ-039 ret_valid gaps in RD_DATA -> fill_data word k equals k-th valid beat.
REQ-040 rstn low during RD_DATA beat 7 -> outputs 0 at once, no fill_we/lru_en, next miss completes normally.
REQ-041 miss pulse during WB_DATA -> ignored, exactly one done per accepted miss.

Source files
------------

// File: rtl/miss_refill_if.sv
// Bundle of signals between the miss refill controller and its environment:
// the miss request side (address buffer, LRU victim, dirty bits, victim line),
// the memory read and writeback channels, and the tag/data RAM fill port.
// Handshakes: a request (rd_req, wr_req) or data beat (wr_valid) is held
// stable until the cycle its ready (rd_rdy, wr_rdy) is sampled high at a
// rising edge; ret_valid beats are accepted unconditionally.
interface miss_refill_if;
    // miss request side
    logic         miss;
    logic [31:0]  addr_rbuf;
    logic [3:0]   way_sel;
    logic [3:0]   dirty;
    logic [19:0]  victim_tag;
    logic [511:0] victim_data;
    // memory read channel
    logic         rd_req;
    logic [31:0]  rd_addr;
    logic         rd_rdy;
    logic         ret_valid;
    logic         ret_last;
    logic [31:0]  ret_data;
    // memory writeback channel
    logic         wr_req;
    logic [31:0]  wr_addr;
    logic         wr_valid;
    logic [31:0]  wr_data;
    logic         wr_last;
    logic         wr_rdy;
    // tag/data RAM fill and LRU update
    logic [3:0]   fill_we;
    logic [5:0]   fill_index;
    logic [19:0]  fill_tag;
    logic [511:0] fill_data;
    logic         lru_en;
    logic [3:0]   lru_visit;
    // status
    logic         busy;
    logic         done;

    // controller side
    modport master (
        input  miss, addr_rbuf, way_sel, dirty, victim_tag, victim_data,
        output rd_req, rd_addr,
        input  rd_rdy, ret_valid, ret_last, ret_data,
        output wr_req, wr_addr, wr_valid, wr_data, wr_last,
        input  wr_rdy,
        output fill_we, fill_index, fill_tag, fill_data, lru_en, lru_visit,
        output busy, done
    );

    // environment side (cache pipeline, memory, RAMs)
    modport slave (
        output miss, addr_rbuf, way_sel, dirty, victim_tag, victim_data,
        input  rd_req, rd_addr,
        output rd_rdy, ret_valid, ret_last, ret_data,
        input  wr_req, wr_addr, wr_valid, wr_data, wr_last,
        output wr_rdy,
        input  fill_we, fill_index, fill_tag, fill_data, lru_en, lru_visit,
        input  busy, done
    );
endinterface

// File: rtl/miss_refill_ctrl.sv
// Cache miss refill controller for a 4-way, 64-set cache with 64-byte lines.
// On a miss it captures the victim, writes it back if dirty (16 beats),
// reads the missing line (burst of up to 16 beats into a refill buffer) and
// then writes the line into the tag/data RAM in a single FILL cycle.
module miss_refill_ctrl (
    input  logic          clk,
    input  logic          rstn,
    miss_refill_if.master bus,
    output logic [2:0]    state_o
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WB_REQ  = 3'd1,
        WB_DATA = 3'd2,
        RD_REQ  = 3'd3,
        RD_DATA = 3'd4,
        FILL    = 3'd5
    } state_t;

    state_t       state_q;
    logic [3:0]   cnt_q;      // beat counter for writeback and read return
    logic [25:0]  line_q;     // missing address bits [31:6]
    logic [3:0]   way_q;      // victim way exactly as presented
    logic [19:0]  vtag_q;
    logic [511:0] vdata_q;
    logic [511:0] buf_q;      // refill buffer, keeps old words on short bursts
    logic         rd_req_q;
    logic         wr_req_q;
    logic         wr_valid_q;
    logic         fill_q;
    logic         busy_q;
    logic         victim_dirty;

    // A non-one-hot way_sel is dirty if any selected way is dirty
    assign victim_dirty = |(bus.dirty & bus.way_sel);

    // Refill sequencer: state, latches, beat counter and output strobes
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            line_q     <= '0;
            way_q      <= '0;
            vtag_q     <= '0;
            vdata_q    <= '0;
            buf_q      <= '0;
            rd_req_q   <= 1'b0;
            wr_req_q   <= 1'b0;
            wr_valid_q <= 1'b0;
            fill_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.miss) begin
                        line_q  <= bus.addr_rbuf[31:6];
                        way_q   <= bus.way_sel;
                        vtag_q  <= bus.victim_tag;
                        vdata_q <= bus.victim_data;
                        busy_q  <= 1'b1;
                        if (victim_dirty) begin
                            wr_req_q <= 1'b1;
                            state_q  <= WB_REQ;
                        end else begin
                            rd_req_q <= 1'b1;
                            state_q  <= RD_REQ;
                        end
                    end
                end
                WB_REQ: begin
                    if (bus.wr_rdy) begin
                        wr_req_q   <= 1'b0;
                        wr_valid_q <= 1'b1;
                        cnt_q      <= 4'd0;
                        state_q    <= WB_DATA;
                    end
                end
                WB_DATA: begin
                    if (bus.wr_rdy) begin
                        if (cnt_q == 4'd15) begin
                            wr_valid_q <= 1'b0;
                            rd_req_q   <= 1'b1;
                            cnt_q      <= 4'd0;
                            state_q    <= RD_REQ;
                        end else begin
                            cnt_q <= cnt_q + 4'd1;
                        end
                    end
                end
                RD_REQ: begin
                    if (bus.rd_rdy) begin
                        rd_req_q <= 1'b0;
                        cnt_q    <= 4'd0;
                        state_q  <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (bus.ret_valid) begin
                        buf_q[{cnt_q, 5'b0} +: 32] <= bus.ret_data;
                        cnt_q <= cnt_q + 4'd1;
                        if (bus.ret_last) begin
                            fill_q  <= 1'b1;
                            state_q <= FILL;
                        end
                    end
                end
                FILL: begin
                    fill_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    cnt_q   <= 4'd0;
                    state_q <= IDLE;
                end
                default: begin
                    rd_req_q   <= 1'b0;
                    wr_req_q   <= 1'b0;
                    wr_valid_q <= 1'b0;
                    fill_q     <= 1'b0;
                    busy_q     <= 1'b0;
                    cnt_q      <= 4'd0;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

    // Address/data outputs are gated by their registered strobes so they
    // read zero whenever the corresponding channel is inactive.
    assign bus.rd_req     = rd_req_q;
    assign bus.rd_addr    = rd_req_q ? {line_q, 6'b0} : 32'd0;
    assign bus.wr_req     = wr_req_q;
    assign bus.wr_addr    = wr_req_q ? {vtag_q, line_q[5:0], 6'b0} : 32'd0;
    assign bus.wr_valid   = wr_valid_q;
    assign bus.wr_data    = wr_valid_q ? vdata_q[{cnt_q, 5'b0} +: 32] : 32'd0;
    assign bus.wr_last    = wr_valid_q && (cnt_q == 4'd15);
    assign bus.fill_we    = fill_q ? way_q : 4'd0;
    assign bus.fill_index = fill_q ? line_q[5:0] : 6'd0;
    assign bus.fill_tag   = fill_q ? line_q[25:6] : 20'd0;
    assign bus.fill_data  = fill_q ? buf_q : 512'd0;
    assign bus.lru_en     = fill_q;
    assign bus.lru_visit  = fill_q ? way_q : 4'd0;
    assign bus.busy       = busy_q;
    assign bus.done       = fill_q;
    assign state_o        = state_q;

endmodule
